// File: rtl/uart_msg_deframer.sv
// Assembles SYNC/LEN/payload/CHK frames from a UART byte stream and presents
// verified payloads on a valid/ready port; framing faults pulse an error flag.
module uart_msg_deframer #(
    parameter int          MAX_LEN      = 8,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter logic [15:0] TIMEOUT_CLKS = 16'd34720
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 msg_valid,
    input  logic                 msg_ready,
    output logic [7:0]           msg_len,
    output logic [8*MAX_LEN-1:0] msg_data,
    output logic                 err_len,
    output logic                 err_chk,
    output logic                 err_timeout,
    output logic                 err_overflow,
    output logic                 busy
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHECK} state_t;

    state_t                     state, state_next;
    logic [7:0]                 len_q, idx_q, chk_q;
    logic [15:0]                tcnt;
    logic [MAX_LEN-1:0][7:0]    wbuf;
    logic [MAX_LEN-1:0][7:0]    msg_buf;

    logic len_bad, chk_bad, tmo, complete, load, ovf;

    always_comb begin
        state_next = state;
        len_bad    = 1'b0;
        chk_bad    = 1'b0;
        tmo        = 1'b0;
        complete   = 1'b0;
        if (state != HUNT && !byte_valid && tcnt == TIMEOUT_CLKS - 16'd1) begin
            tmo        = 1'b1;
            state_next = HUNT;
        end else if (byte_valid) begin
            case (state)
                HUNT: begin
                    if (byte_data == SYNC_BYTE)
                        state_next = LEN;
                end
                LEN: begin
                    // A rejected LEN byte is consumed; it never restarts a frame.
                    if (byte_data == 8'd0 || byte_data > MAX_LEN_B) begin
                        len_bad    = 1'b1;
                        state_next = HUNT;
                    end else begin
                        state_next = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (idx_q == len_q - 8'd1)
                        state_next = CHECK;
                end
                CHECK: begin
                    state_next = HUNT;
                    if (byte_data == chk_q)
                        complete = 1'b1;
                    else
                        chk_bad = 1'b1;
                end
                default: state_next = HUNT;
            endcase
        end
    end

    // A completion may load on the same cycle the held message is taken.
    assign load = complete && (!msg_valid || msg_ready);
    assign ovf  = complete && msg_valid && !msg_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HUNT;
            len_q        <= '0;
            idx_q        <= '0;
            chk_q        <= '0;
            tcnt         <= '0;
            wbuf         <= '0;
            msg_buf      <= '0;
            msg_valid    <= 1'b0;
            msg_len      <= '0;
            err_len      <= 1'b0;
            err_chk      <= 1'b0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            state <= state_next;

            if (byte_valid || state == HUNT)
                tcnt <= '0;
            else if (tcnt != 16'hFFFF)
                tcnt <= tcnt + 16'd1;

            if (byte_valid && !tmo) begin
                case (state)
                    LEN: begin
                        if (!len_bad) begin
                            len_q <= byte_data;
                            chk_q <= byte_data;
                            idx_q <= '0;
                            wbuf  <= '0;
                        end
                    end
                    PAYLOAD: begin
                        for (int i = 0; i < MAX_LEN; i++)
                            if (idx_q == 8'(i))
                                wbuf[i] <= byte_data;
                        chk_q <= chk_q ^ byte_data;
                        idx_q <= idx_q + 8'd1;
                    end
                    default: ;
                endcase
            end

            if (load) begin
                msg_valid <= 1'b1;
                msg_len   <= len_q;
                msg_buf   <= wbuf;
            end else if (msg_valid && msg_ready) begin
                msg_valid <= 1'b0;
            end

            err_len      <= len_bad;
            err_chk      <= chk_bad;
            err_timeout  <= tmo;
            err_overflow <= ovf;
        end
    end

    assign msg_data = msg_buf;
    assign busy     = (state != HUNT);

endmodule

// File: tb/tb_uart_msg_deframer.sv
// Directed bench for uart_msg_deframer: a per-cycle vector table plus
// hand-written timeout, overflow and reset sequences.
module tb_uart_msg_deframer;

    localparam int MAX_LEN = 8;
    localparam logic [3:0] EL = 4'b1000, EC = 4'b0100, ET = 4'b0010, EO = 4'b0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        msg_valid;
    logic        msg_ready;
    logic [7:0]  msg_len;
    logic [63:0] msg_data;
    logic        err_len, err_chk, err_timeout, err_overflow;
    logic        busy;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    uart_msg_deframer #(
        .MAX_LEN(MAX_LEN), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(16'd100)
    ) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_len(msg_len),
        .msg_data(msg_data), .err_len(err_len), .err_chk(err_chk),
        .err_timeout(err_timeout), .err_overflow(err_overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        r;
        logic        ev;
        logic [7:0]  el;
        logic [63:0] ed;
        logic [3:0]  er;
        logic        eb;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic v, input logic [7:0] d, input logic r,
                                input logic ev, input logic [7:0] el, input logic [63:0] ed,
                                input logic [3:0] er, input logic eb);
        vec_t t;
        t.v = v; t.d = d; t.r = r; t.ev = ev; t.el = el; t.ed = ed; t.er = er; t.eb = eb;
        tbl.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic r);
        byte_valid = v; byte_data = d; msg_ready = r;
        @(posedge clk); #1;
    endtask

    task automatic exp_out(input string tag, input logic ev, input logic [7:0] el,
                           input logic [63:0] ed, input logic [3:0] er, input logic eb);
        chk({tag, " msg_valid"}, 64'(msg_valid), 64'(ev));
        if (ev) begin
            chk({tag, " msg_len"}, 64'(msg_len), 64'(el));
            chk({tag, " msg_data"}, msg_data, ed);
        end
        chk({tag, " errs"}, 64'({err_len, err_chk, err_timeout, err_overflow}), 64'(er));
        chk({tag, " busy"}, 64'(busy), 64'(eb));
    endtask

    task automatic send(input string tag, input logic [7:0] d, input logic r,
                        input logic ev, input logic [7:0] el, input logic [63:0] ed,
                        input logic [3:0] er, input logic eb);
        cyc(1'b1, d, r);
        exp_out(tag, ev, el, ed, er, eb);
    endtask

    initial begin
        rst = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; msg_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset msg_len", 64'(msg_len), 64'd0);
        chk("reset msg_data", msg_data, 64'd0);
        exp_out("reset", 1'b0, 8'd0, 64'd0, 4'd0, 1'b0);
        rst = 1'b0;

        // noise then 3-byte frame, held with ready low, then taken
        add(1, 8'h00, 0, 0, 0, 0, 0, 0);
        add(1, 8'hFF, 0, 0, 0, 0, 0, 0);
        add(1, 8'hA5, 0, 0, 0, 0, 0, 1);
        add(1, 8'h03, 0, 0, 0, 0, 0, 1);
        add(1, 8'h11, 0, 0, 0, 0, 0, 1);
        add(1, 8'h22, 0, 0, 0, 0, 0, 1);
        add(1, 8'h33, 0, 0, 0, 0, 0, 1);
        add(1, 8'h03, 0, 1, 3, 64'h332211, 0, 0);
        add(0, 8'h00, 0, 1, 3, 64'h332211, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0);
        // back-to-back strobes, valid exactly one clock
        add(1, 8'hA5, 1, 0, 0, 0, 0, 1);
        add(1, 8'h01, 1, 0, 0, 0, 0, 1);
        add(1, 8'h7E, 1, 0, 0, 0, 0, 1);
        add(1, 8'h7F, 1, 1, 1, 64'h7E, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0);
        // checksum error (expected FD), then a good frame
        add(1, 8'hA5, 1, 0, 0, 0, 0, 1);
        add(1, 8'h02, 1, 0, 0, 0, 0, 1);
        add(1, 8'hAA, 1, 0, 0, 0, 0, 1);
        add(1, 8'h55, 1, 0, 0, 0, 0, 1);
        add(1, 8'h00, 1, 0, 0, 0, EC, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0);
        add(1, 8'hA5, 1, 0, 0, 0, 0, 1);
        add(1, 8'h01, 1, 0, 0, 0, 0, 1);
        add(1, 8'h10, 1, 0, 0, 0, 0, 1);
        add(1, 8'h11, 1, 1, 1, 64'h10, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0);
        // length errors: too long, zero, and SYNC value as LEN not re-examined
        add(1, 8'hA5, 1, 0, 0, 0, 0, 1);
        add(1, 8'h09, 1, 0, 0, 0, EL, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0);
        add(1, 8'hA5, 1, 0, 0, 0, 0, 1);
        add(1, 8'h00, 1, 0, 0, 0, EL, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0);
        add(1, 8'hA5, 1, 0, 0, 0, 0, 1);
        add(1, 8'hA5, 1, 0, 0, 0, EL, 0);
        add(1, 8'h01, 1, 0, 0, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0);
        // maximum-length frame; payload XOR 08 ^ LEN 08 = 00
        add(1, 8'hA5, 1, 0, 0, 0, 0, 1);
        add(1, 8'h08, 1, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) add(1, 8'(i), 1, 0, 0, 0, 0, 1);
        add(1, 8'h00, 1, 1, 8, 64'h0807060504030201, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].r);
            exp_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].el, tbl[i].ed, tbl[i].er, tbl[i].eb);
        end

        // timeout after 100 idle clocks mid-frame
        send("to sync", 8'hA5, 1, 0, 0, 0, 0, 1);
        send("to len", 8'h02, 1, 0, 0, 0, 0, 1);
        send("to p0", 8'h10, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 99; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            exp_out("to idle", 0, 0, 0, 0, 1);
        end
        cyc(1'b0, 8'h00, 1'b1);
        exp_out("to fire", 0, 0, 0, ET, 0);
        cyc(1'b0, 8'h00, 1'b1);
        exp_out("to after", 0, 0, 0, 0, 0);
        send("to2 sync", 8'hA5, 1, 0, 0, 0, 0, 1);
        send("to2 len", 8'h01, 1, 0, 0, 0, 0, 1);
        send("to2 p0", 8'h10, 1, 0, 0, 0, 0, 1);
        send("to2 chk", 8'h11, 1, 1, 1, 64'h10, 0, 0);

        // byte on the threshold cycle wins
        send("thr sync", 8'hA5, 1, 0, 0, 0, 0, 1);
        send("thr len", 8'h02, 1, 0, 0, 0, 0, 1);
        send("thr p0", 8'h10, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 99; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            exp_out("thr idle", 0, 0, 0, 0, 1);
        end
        send("thr p1", 8'h20, 1, 0, 0, 0, 0, 1);
        send("thr chk", 8'h32, 1, 1, 2, 64'h2010, 0, 0);
        cyc(1'b0, 8'h00, 1'b1);
        exp_out("thr taken", 0, 0, 0, 0, 0);

        // overflow while held, then load coinciding with a transfer
        send("ov a0", 8'hA5, 0, 0, 0, 0, 0, 1);
        send("ov a1", 8'h01, 0, 0, 0, 0, 0, 1);
        send("ov a2", 8'h10, 0, 0, 0, 0, 0, 1);
        send("ov a3", 8'h11, 0, 1, 1, 64'h10, 0, 0);
        send("ov b0", 8'hA5, 0, 1, 1, 64'h10, 0, 1);
        send("ov b1", 8'h01, 0, 1, 1, 64'h10, 0, 1);
        send("ov b2", 8'h20, 0, 1, 1, 64'h10, 0, 1);
        send("ov b3", 8'h21, 0, 1, 1, 64'h10, EO, 0);
        cyc(1'b0, 8'h00, 1'b0);
        exp_out("ov hold", 1, 1, 64'h10, 0, 0);
        send("sw c0", 8'hA5, 0, 1, 1, 64'h10, 0, 1);
        send("sw c1", 8'h01, 0, 1, 1, 64'h10, 0, 1);
        send("sw c2", 8'h30, 0, 1, 1, 64'h10, 0, 1);
        send("sw c3", 8'h31, 1, 1, 1, 64'h30, 0, 0);
        cyc(1'b0, 8'h00, 1'b0);
        exp_out("sw hold", 1, 1, 64'h30, 0, 0);

        // reset mid-frame with a held message: both discarded silently
        send("rs s", 8'hA5, 0, 1, 1, 64'h30, 0, 1);
        send("rs l", 8'h03, 0, 1, 1, 64'h30, 0, 1);
        send("rs p", 8'h11, 0, 1, 1, 64'h30, 0, 1);
        rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        chk("rs msg_len", 64'(msg_len), 64'd0);
        chk("rs msg_data", msg_data, 64'd0);
        exp_out("rs now", 0, 0, 0, 0, 0);
        send("rs 22", 8'h22, 1, 0, 0, 0, 0, 0);
        send("rs 33", 8'h33, 1, 0, 0, 0, 0, 0);
        send("rs 03", 8'h03, 1, 0, 0, 0, 0, 0);
        cyc(1'b0, 8'h00, 1'b1);
        exp_out("rs end", 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/uart_msg_deframer.md
Name: uart_msg_deframer

Overview:
Consumes the byte stream produced by the UART receiver (one-cycle byte strobe plus 8-bit data) and assembles framed order messages. Frame format is SYNC, LEN, LEN payload bytes, CHK. Verified messages are presented on a valid/ready output port to the order-handling logic. Framing, length, checksum, inter-byte timeout and output-overflow errors are flagged as one-cycle pulses.

Parameters:
MAX_LEN, 8, maximum payload bytes per frame (1..255).
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CLKS, 16'd34720, maximum idle clocks between bytes inside a frame (about 2 byte-times at 1736 clk/bit).

Ports:
clk  in  1  system clock, all logic on posedge.
rst  in  1  synchronous active-high reset.
byte_valid  in  1  one-cycle strobe, byte_data valid; strobes may arrive on back-to-back cycles.
byte_data  in  8  received byte.
msg_valid  out  1  output message available.
msg_ready  in  1  consumer accepts message when high with msg_valid.
msg_len  out  8  payload length of presented message (1..MAX_LEN).
msg_data  out  8*MAX_LEN  payload; byte i at [8i+7:8i]; bytes at index >= msg_len are 0.
err_len  out  1  pulse: LEN byte was 0 or greater than MAX_LEN.
err_chk  out  1  pulse: checksum mismatch.
err_timeout  out  1  pulse: inter-byte gap expired mid-frame.
err_overflow  out  1  pulse: good frame dropped because output was still held.
busy  out  1  high whenever state != HUNT.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset (synchronous, rst=1 at posedge): state=HUNT; all outputs 0; working buffer, index, checksum and timeout counter cleared. A frame in progress is discarded with no error pulse. A held output message is dropped.
- States: HUNT, LEN, PAYLOAD, CHECK. A byte is consumed only on a cycle with byte_valid=1.
- HUNT: byte == SYNC_BYTE -> LEN. Any other byte is ignored silently.
- LEN: byte == 0 or byte > MAX_LEN -> err_len pulse, go to HUNT. That byte is not re-examined as SYNC.
  Otherwise: store len, set chk = byte, idx = 0, zero the working buffer -> PAYLOAD.
- PAYLOAD: buf[idx] = byte; chk ^= byte; idx++. The byte received when idx == len-1 moves to CHECK.
- CHECK: byte == chk -> frame good (completion). Otherwise err_chk pulse. Either case -> HUNT.
- Completion load: if msg_valid==0, or msg_valid && msg_ready in the same cycle, load msg_len and msg_data from the working buffer. msg_valid=1 on the next cycle, i.e. latency 1 clk after the CHK byte strobe.
- Completion when output is still held (msg_valid && !msg_ready): err_overflow pulse; the new frame is dropped; the held message stays unchanged.
- Output handshake: msg_valid stays high until msg_ready is sampled high. msg_len and msg_data stay stable while msg_valid=1. A transfer clears msg_valid next cycle unless a completion loads on the same cycle, in which case msg_valid stays 1 with the new data.
- Timeout counter:
  - Cleared on every byte_valid and while in HUNT; increments otherwise.
  - In LEN, PAYLOAD or CHECK, reaching TIMEOUT_CLKS-1 with no byte_valid -> err_timeout pulse, go to HUNT.
  - If byte_valid coincides with the threshold cycle, the byte wins: it is processed, the counter is cleared, no timeout fires.
- Error pulses are exactly 1 clk wide, registered, and asserted the cycle after the causing event. At most one error fires per byte.
- Width rules: chk is 8-bit XOR; idx is 8-bit; the timeout counter is 16-bit and saturating.

Test Plan:
- Noise then frame: bytes 00,FF,A5,03,11,22,33,03 -> msg_valid=1 one clk after last strobe, msg_len=3, msg_data[23:0]=24'h332211, upper bytes 0, no error pulses.
- Back-to-back strobes: A5,01,7E,7F on 4 consecutive cycles, msg_ready=1 -> msg_len=1, msg_data[7:0]=8'h7E; msg_valid high exactly 1 clk.
- Checksum error: A5,02,AA,55,00 (expected chk FD) -> err_chk single pulse, no msg_valid. A following A5,01,10,11 is then accepted.
- Length errors (MAX_LEN=8): A5,09 -> err_len. A5,00 -> err_len. Both return to HUNT; busy=0 afterwards.
- Timeout (TIMEOUT_CLKS=100): A5,02,10 then 100 idle clks -> err_timeout; busy drops. A subsequent valid frame is accepted normally. Repeat with a byte arriving on the threshold cycle -> no timeout.
- Overflow and reset: msg_ready=0, send two good frames -> first held unchanged, err_overflow on second. Then release msg_ready. Separately: A5,03,11, rst for 1 clk, then 22,33,03 -> no msg_valid and no error pulse.
